// File: rtl/arb4_pkg.sv
// Shared types and the rotating-priority winner search for the 4-way round-robin arbiter.
package arb4_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic [0:0] {IDLE, GRANT} arb_state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } arb_win_t;

   // First set request at or after ptr, wrapping 3->0.
   function automatic arb_win_t arb_search(input logic [N_REQ-1:0] req,
                                           input logic [IDX_W-1:0] ptr);
      arb_win_t         w;
      logic [IDX_W-1:0] cand;
      w.found = 1'b0;
      w.idx   = '0;
      // Walk from the farthest offset down so the nearest hit is kept last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            w.found = 1'b1;
            w.idx   = cand;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/arb_onehot_dec.sv
// One-hot grant decoder: expands the owner index into the grant vector when enabled.
module arb_onehot_dec
   import arb4_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N_REQ-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (en) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/arb4_rr.sv
// 4-way round-robin arbiter with registered grant. Define ARB4_RR_TIMEOUT_EN to add the
// MAX_HOLD forced hand-off; otherwise grants are held until the owner releases.
module arb4_rr
   import arb4_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_en,
   output logic             timeout
);

   arb_state_e       state_q;
   logic [IDX_W-1:0] idx_q;
   logic             en_q;
   logic [IDX_W-1:0] ptr_q;

   arb_win_t win_idle;
   arb_win_t win_next;
   logic     rel;
   logic     expire;
   logic     handoff;

   assign win_idle = arb_search(req, ptr_q);
   assign win_next = arb_search(req, idx_q + 2'd1);
   assign rel      = (state_q == GRANT) && !req[idx_q];
   assign handoff  = rel || expire;

`ifdef ARB4_RR_TIMEOUT_EN
   logic [7:0] hold_q;
   logic       timeout_q;

   assign expire = (state_q == GRANT) && req[idx_q] && (hold_q == 8'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         // Idle and every hand-off restart the count for the next owner.
         hold_q    <= (state_q == GRANT && !handoff) ? hold_q + 8'd1 : 8'd0;
         timeout_q <= expire;
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_max_hold;
   assign unused_max_hold = ^8'(MAX_HOLD);
   assign expire          = 1'b0;
   assign timeout         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         en_q    <= 1'b0;
         ptr_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (win_idle.found) begin
                  state_q <= GRANT;
                  idx_q   <= win_idle.idx;
                  en_q    <= 1'b1;
               end
            end
            GRANT: begin
               if (handoff) begin
                  ptr_q <= idx_q + 2'd1;
                  if (win_next.found) begin
                     idx_q <= win_next.idx;
                  end else begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                     en_q    <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
               en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_idx = idx_q;
   assign gnt_en  = en_q;

   arb_onehot_dec u_dec (
      .idx (idx_q),
      .en  (en_q),
      .gnt (gnt)
   );

endmodule
